cyclic_decode: RTL and testbench



---
 rtl/cyclic_decode_pkg.sv | 24 ++
 rtl/cyclic_syndrome_lut.sv | 26 ++
 rtl/cyclic_decode.sv | 127 ++++++++++++
 tb/tb_cyclic_decode.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/cyclic_decode_pkg.sv
// Shared definitions for the serial (7,4) cyclic code built on g(x) = x^3 + x + 1.
// Used by the decoder and the syndrome table; the feedback mask also serves the encoder side.
package cyclic_decode_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RECV = 2'b01,
        ST_DEC  = 2'b10,
        ST_OUT  = 2'b11
    } dec_state_e;

    localparam int CW_LEN  = 7;
    localparam int MSG_LEN = 4;
    localparam int PAR_LEN = 3;

    // Low-order terms of g(x): x^3 folds back into x + 1.
    localparam logic [PAR_LEN-1:0] GEN_MASK = 3'b011;

    // One step of the division register: shift in the next bit, fold back on overflow.
    function automatic logic [PAR_LEN-1:0] syn_step(input logic [PAR_LEN-1:0] s, input logic bit_in);
        syn_step = {s[PAR_LEN-2:0], bit_in} ^ (s[PAR_LEN-1] ? GEN_MASK : '0);
    endfunction

endpackage

// File: rtl/cyclic_syndrome_lut.sv
// Maps a 3-bit syndrome to the degree of the single bit it implicates (x^d mod g(x)).
// Pure combinational so a detect-only checker can share it.
module cyclic_syndrome_lut
    import cyclic_decode_pkg::*;
(
    input  logic [2:0] syn,
    output logic       hit,
    output logic [2:0] deg
);

    always_comb begin
        hit = 1'b1;
        deg = 3'd0;
        case (syn)
            3'b001:  deg = 3'd0;
            3'b010:  deg = 3'd1;
            3'b100:  deg = 3'd2;
            3'b011:  deg = 3'd3;
            3'b110:  deg = 3'd4;
            3'b111:  deg = 3'd5;
            3'b101:  deg = 3'd6;
            default: hit = 1'b0;
        endcase
    end

endmodule

// File: rtl/cyclic_decode.sv
// Serial (7,4) cyclic decoder: accumulates the syndrome while the codeword streams in,
// then replays the four message bits with the single implicated bit optionally flipped.
module cyclic_decode
    import cyclic_decode_pkg::*;
#(
    parameter bit CORRECT_EN = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic din,
    input  logic din_valid,
    output logic dout,
    output logic dout_valid,
    output logic err_flag,
    output logic frame_done,
    output logic busy
);

    localparam logic [2:0] LAST_RX  = 3'(CW_LEN - 1);
    localparam logic [2:0] LAST_OUT = 3'(MSG_LEN - 1);
    localparam logic [2:0] TOP_DEG  = 3'(CW_LEN - 1);

    dec_state_e         state_q, state_d;
    logic [2:0]         cnt_q, cnt_d;
    logic [PAR_LEN-1:0] syn_q, syn_d;
    logic [CW_LEN-1:0]  cw_buf_q, cw_buf_d;
    logic               dout_q, dout_d;
    logic               dout_valid_q, dout_valid_d;
    logic               err_flag_q, err_flag_d;
    logic               frame_done_q, frame_done_d;

    logic       err_hit;
    logic [2:0] err_deg;
    logic [2:0] out_deg;

    // Syndrome is frozen from DEC onward, so the table output stays stable through OUT.
    cyclic_syndrome_lut u_lut (
        .syn (syn_q),
        .hit (err_hit),
        .deg (err_deg)
    );

    assign out_deg = TOP_DEG - cnt_q;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        syn_d        = syn_q;
        cw_buf_d     = cw_buf_q;
        dout_d       = 1'b0;
        dout_valid_d = 1'b0;
        err_flag_d   = err_flag_q;
        frame_done_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                err_flag_d = 1'b0;
                if (start) begin
                    state_d  = ST_RECV;
                    cnt_d    = '0;
                    syn_d    = '0;
                    cw_buf_d = '0;
                end
            end
            ST_RECV: begin
                if (din_valid) begin
                    cw_buf_d = {cw_buf_q[CW_LEN-2:0], din};
                    syn_d    = syn_step(syn_q, din);
                    if (cnt_q == LAST_RX) begin
                        state_d = ST_DEC;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 3'd1;
                    end
                end
            end
            ST_DEC: begin
                err_flag_d = err_hit;
                state_d    = ST_OUT;
                cnt_d      = '0;
            end
            ST_OUT: begin
                dout_valid_d = 1'b1;
                dout_d       = cw_buf_q[out_deg] ^ (CORRECT_EN && err_hit && (err_deg == out_deg));
                if (cnt_q == LAST_OUT) begin
                    // Drop to IDLE with the last bit so start is taken on the very next edge.
                    frame_done_d = 1'b1;
                    state_d      = ST_IDLE;
                    cnt_d        = '0;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            syn_q        <= '0;
            cw_buf_q     <= '0;
            dout_q       <= 1'b0;
            dout_valid_q <= 1'b0;
            err_flag_q   <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            syn_q        <= syn_d;
            cw_buf_q     <= cw_buf_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
            err_flag_q   <= err_flag_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;
    assign err_flag   = err_flag_q;
    assign frame_done = frame_done_q;
    assign busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_cyclic_decode.sv
// Bench for cyclic_decode: a correcting and a detect-only instance share one input stream;
// expectations come from polynomial arithmetic over GF(2) modulo x^3 + x + 1.
module tb_cyclic_decode;

    logic clk = 1'b0;
    logic rst, start, din, din_valid;
    logic dout, dout_valid, err_flag, frame_done, busy;
    logic dout_n, dout_valid_n, err_flag_n, frame_done_n, busy_n;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    cyclic_decode #(.CORRECT_EN(1'b1)) u_ce (
        .clk(clk), .rst(rst), .start(start), .din(din), .din_valid(din_valid),
        .dout(dout), .dout_valid(dout_valid), .err_flag(err_flag),
        .frame_done(frame_done), .busy(busy)
    );

    cyclic_decode #(.CORRECT_EN(1'b0)) u_nc (
        .clk(clk), .rst(rst), .start(start), .din(din), .din_valid(din_valid),
        .dout(dout_n), .dout_valid(dout_valid_n), .err_flag(err_flag_n),
        .frame_done(frame_done_n), .busy(busy_n)
    );

    // x^d mod g(x), as a 3-bit remainder.
    function automatic logic [2:0] xpow(input int d);
        logic [3:0] p;
        p = 4'b0001;
        for (int k = 0; k < d; k++) begin
            p = p << 1;
            if (p >= 4'd8) p = p ^ 4'b1011;
        end
        return p[2:0];
    endfunction

    function automatic logic [2:0] remainder(input logic [6:0] cw);
        logic [2:0] r;
        r = 3'b000;
        for (int d = 0; d < 7; d++) if (cw[d]) r = r ^ xpow(d);
        return r;
    endfunction

    function automatic int implicated_degree(input logic [6:0] cw);
        logic [2:0] r;
        r = remainder(cw);
        if (r == 3'b000) return -1;
        for (int d = 0; d < 7; d++) if (xpow(d) == r) return d;
        return -1;
    endfunction

    function automatic logic [6:0] encode(input logic [3:0] msg);
        logic [2:0] par;
        par = 3'b000;
        for (int i = 0; i < 4; i++) if (msg[i]) par = par ^ xpow(i + 3);
        return {msg, par};
    endfunction

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives start plus one codeword (optional stall before bit gap_pos) and checks the output frame.
    // Returns right after the edge carrying the last message bit.
    task automatic run_frame(input string name, input logic [6:0] cw, input int gap_pos,
                             input int gap_len, input bit mid_start);
        int         edeg;
        logic [3:0] exp_ce, exp_nc;
        logic       eflag;
        edeg  = implicated_degree(cw);
        eflag = (remainder(cw) != 3'b000);
        for (int j = 0; j < 4; j++) begin
            exp_nc[3-j] = cw[6-j];
            exp_ce[3-j] = cw[6-j] ^ (edeg == 6 - j);
        end

        start = 1'b1; din_valid = 1'b0;
        tick();
        start = 1'b0;
        chk({name, ".busy_start"}, {7'd0, busy}, 8'd1);
        chk({name, ".dv_start"}, {7'd0, dout_valid}, 8'd0);
        chk({name, ".err_start"}, {7'd0, err_flag}, 8'd0);

        for (int i = 0; i < 7; i++) begin
            if (i == gap_pos) begin
                for (int g = 0; g < gap_len; g++) begin
                    din_valid = 1'b0;
                    din       = $urandom_range(0, 1);
                    start     = mid_start;
                    tick();
                    start = 1'b0;
                end
            end
            din = cw[6-i]; din_valid = 1'b1;
            tick();
        end
        din_valid = 1'b0; din = 1'b0;

        tick();
        chk({name, ".dv_dec"}, {7'd0, dout_valid}, 8'd0);
        chk({name, ".busy_dec"}, {7'd0, busy}, 8'd1);

        for (int j = 0; j < 4; j++) begin
            tick();
            chk($sformatf("%s.dv%0d", name, j), {7'd0, dout_valid}, 8'd1);
            chk($sformatf("%s.dout%0d", name, j), {7'd0, dout}, {7'd0, exp_ce[3-j]});
            chk($sformatf("%s.err%0d", name, j), {7'd0, err_flag}, {7'd0, eflag});
            chk($sformatf("%s.fd%0d", name, j), {7'd0, frame_done}, {7'd0, (j == 3)});
            chk($sformatf("%s.nc_dout%0d", name, j), {7'd0, dout_n}, {7'd0, exp_nc[3-j]});
            chk($sformatf("%s.nc_err%0d", name, j), {7'd0, err_flag_n}, {7'd0, eflag});
            chk($sformatf("%s.nc_dv%0d", name, j), {7'd0, dout_valid_n}, 8'd1);
        end
        chk({name, ".busy_end"}, {7'd0, busy}, 8'd0);
    endtask

    task automatic idle_checks(input string name, input int n);
        for (int k = 0; k < n; k++) begin
            din_valid = 1'b1;
            din       = $urandom_range(0, 1);
            tick();
            chk($sformatf("%s.busy%0d", name, k), {7'd0, busy}, 8'd0);
            chk($sformatf("%s.dv%0d", name, k), {7'd0, dout_valid}, 8'd0);
            chk($sformatf("%s.fd%0d", name, k), {7'd0, frame_done}, 8'd0);
            chk($sformatf("%s.err%0d", name, k), {7'd0, err_flag}, 8'd0);
        end
        din_valid = 1'b0;
    endtask

    initial begin
        logic [6:0] cw;
        logic [3:0] msg;
        int         e;

        rst = 1'b1; start = 1'b0; din = 1'b0; din_valid = 1'b0;
        #2;
        chk("reset.dout", {7'd0, dout}, 8'd0);
        chk("reset.dv", {7'd0, dout_valid}, 8'd0);
        chk("reset.err", {7'd0, err_flag}, 8'd0);
        chk("reset.fd", {7'd0, frame_done}, 8'd0);
        chk("reset.busy", {7'd0, busy}, 8'd0);
        tick(); tick();
        rst = 1'b0;
        tick();

        idle_checks("idle_din", 3);
        run_frame("clean", 7'b1011000, 7, 0, 1'b0);
        idle_checks("post_clean", 1);
        run_frame("deg5", 7'b1100101, 7, 0, 1'b0);
        idle_checks("post_deg5", 1);
        run_frame("deg0", 7'b1000100, 7, 0, 1'b0);
        idle_checks("post_deg0", 1);
        run_frame("deg6", 7'b0000101, 7, 0, 1'b0);
        idle_checks("post_deg6", 1);
        run_frame("stall", 7'b1011000, 2, 3, 1'b1);
        idle_checks("post_stall", 1);

        // Reset mid-frame, then a fresh frame must show no residue.
        start = 1'b1; tick(); start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            din = 1'b1; din_valid = 1'b1; tick();
        end
        din_valid = 1'b0;
        rst = 1'b1;
        #1;
        chk("midrst.busy", {7'd0, busy}, 8'd0);
        chk("midrst.dv", {7'd0, dout_valid}, 8'd0);
        chk("midrst.dout", {7'd0, dout}, 8'd0);
        chk("midrst.err", {7'd0, err_flag}, 8'd0);
        chk("midrst.nc_busy", {7'd0, busy_n}, 8'd0);
        tick();
        rst = 1'b0;
        tick();
        run_frame("after_rst", 7'b1000101, 7, 0, 1'b0);

        // Back-to-back: the next start lands on the first IDLE edge.
        run_frame("b2b_a", 7'b1000101, 7, 0, 1'b0);
        run_frame("b2b_b", 7'b1011000 ^ 7'b0001000, 7, 0, 1'b0);
        idle_checks("post_b2b", 1);

        for (int n = 0; n < 24; n++) begin
            msg = 4'($urandom_range(0, 15));
            cw  = encode(msg);
            e   = $urandom_range(0, 7);
            if (e < 7) cw[e] = ~cw[e];
            run_frame($sformatf("rnd%0d", n), cw, $urandom_range(0, 7),
                      $urandom_range(0, 3), 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 1) == 1) idle_checks($sformatf("rnd_idle%0d", n), 1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
